// File: rtl/vga_pat_sched_if.sv
// Control/status bundle between the key logic, the pattern scheduler and vga_pic.
// The master side drives vsync and the key pulses; the slave side, the scheduler, returns the pattern state.
interface vga_pat_sched_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             vsync;
    logic             key_next;
    logic             key_mode;
    logic [PAT_W-1:0] pat_sel;
    logic             pat_chg;
    logic             mode;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output vsync,
        output key_next,
        output key_mode,
        input  pat_sel,
        input  pat_chg,
        input  mode,
        input  frame_cnt
    );

    modport slave (
        input  vsync,
        input  key_next,
        input  key_mode,
        output pat_sel,
        output pat_chg,
        output mode,
        output frame_cnt
    );
endinterface

// File: rtl/vga_pat_sched.sv
// Frame-synchronous test-pattern scheduler: pat_sel only changes on the edge that
// first samples vsync asserted, either on a key request (MANUAL) or every FRAME_HOLD frames (AUTO).
module vga_pat_sched #(
    parameter int PAT_W      = 3,
    parameter int PAT_NUM    = 8,
    parameter int FRAME_HOLD = 60,
    parameter int CNT_W      = 8,
    parameter bit VS_POL     = 1'b1
) (
    input  logic                  vga_clk,
    input  logic                  sys_rst_n,
    vga_pat_sched_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_MANUAL   = 2'd0,
        ST_MAN_PEND = 2'd1,
        ST_AUTO     = 2'd2
    } state_t;

    localparam logic [PAT_W-1:0] PAT_LAST  = PAT_W'(PAT_NUM - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FRAME_HOLD - 1);

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             vs_d1_q, vs_d1_d;
    logic [PAT_W-1:0] pat_sel_q, pat_sel_d;
    logic             pat_chg_q, pat_chg_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             fs;
    logic             advance;

    // A frame starts on the first cycle vsync is seen at its asserted level.
    assign fs = (bus.vsync == VS_POL) && (vs_d1_q != VS_POL);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        vs_d1_d     = bus.vsync;
        advance     = 1'b0;

        if (bus.key_mode) begin
            // Mode toggle outranks both a coincident key_next and a coincident frame start.
            state_d     = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
            pend_d      = 1'b0;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    frame_cnt_d = '0;
                    if (bus.key_next) begin
                        if (fs) begin
                            advance = 1'b1;
                        end else begin
                            state_d = ST_MAN_PEND;
                        end
                    end
                end
                ST_MAN_PEND: begin
                    frame_cnt_d = '0;
                    if (fs) begin
                        advance = 1'b1;
                        state_d = ST_MANUAL;
                    end
                end
                ST_AUTO: begin
                    if (fs) begin
                        if ((frame_cnt_q == HOLD_LAST) || pend_q || bus.key_next) begin
                            advance     = 1'b1;
                            frame_cnt_d = '0;
                            pend_d      = 1'b0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end else if (bus.key_next) begin
                        pend_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_MANUAL;
                    pend_d      = 1'b0;
                    frame_cnt_d = '0;
                end
            endcase
        end

        pat_sel_d = pat_sel_q;
        if (advance) begin
            pat_sel_d = (pat_sel_q == PAT_LAST) ? '0 : pat_sel_q + 1'b1;
        end
        pat_chg_d = advance;
        mode_d    = (state_d == ST_AUTO);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_MANUAL;
            pend_q      <= 1'b0;
            // Preset to asserted so a vsync already high at reset release is not a frame start.
            vs_d1_q     <= VS_POL;
            pat_sel_q   <= '0;
            pat_chg_q   <= 1'b0;
            mode_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            vs_d1_q     <= vs_d1_d;
            pat_sel_q   <= pat_sel_d;
            pat_chg_q   <= pat_chg_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.pat_sel   = pat_sel_q;
    assign bus.pat_chg   = pat_chg_q;
    assign bus.mode      = mode_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pat_sched.sv
// Directed bench for vga_pat_sched (PAT_NUM=5, FRAME_HOLD=3) with a request/frame-count
// reference model compared every cycle, plus hand-computed checkpoints.
module tb_vga_pat_sched;

    localparam int PAT_W      = 3;
    localparam int PAT_NUM    = 5;
    localparam int FRAME_HOLD = 3;
    localparam int CNT_W      = 8;

    logic clk;
    logic rst_n;

    vga_pat_sched_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    vga_pat_sched #(
        .PAT_W     (PAT_W),
        .PAT_NUM   (PAT_NUM),
        .FRAME_HOLD(FRAME_HOLD),
        .CNT_W     (CNT_W),
        .VS_POL    (1'b1)
    ) dut (
        .vga_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    // Reference model: a request flag, a frame counter and the pattern number.
    int m_pat;
    int m_cnt;
    bit m_mode;
    bit m_req;
    bit m_chg;
    bit m_prev_vs;

    always @(posedge clk or negedge rst_n) begin
        bit fs;
        bit bump;
        if (!rst_n) begin
            m_pat = 0; m_cnt = 0; m_mode = 0; m_req = 0; m_chg = 0; m_prev_vs = 1;
        end else begin
            fs        = bus.vsync && !m_prev_vs;
            m_prev_vs = bus.vsync;
            bump      = 0;
            if (bus.key_mode) begin
                m_mode = !m_mode;
                m_req  = 0;
                m_cnt  = 0;
            end else if (!m_mode) begin
                if (bus.key_next) m_req = 1;
                if (fs && m_req) begin
                    bump  = 1;
                    m_req = 0;
                end
            end else begin
                if (bus.key_next) m_req = 1;
                if (fs) begin
                    if (m_req || (m_cnt + 1 == FRAME_HOLD)) begin
                        bump  = 1;
                        m_req = 0;
                        m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end
            if (bump) m_pat = (m_pat + 1) % PAT_NUM;
            m_chg = bump;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("cyc_pat_sel", int'(bus.pat_sel), m_pat);
        check("cyc_pat_chg", int'(bus.pat_chg), int'(m_chg));
        check("cyc_mode", int'(bus.mode), int'(m_mode));
        check("cyc_frame_cnt", int'(bus.frame_cnt), m_cnt);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_next();
        @(negedge clk); bus.key_next = 1'b1;
        @(negedge clk); bus.key_next = 1'b0;
    endtask

    task automatic pulse_mode();
        @(negedge clk); bus.key_mode = 1'b1;
        @(negedge clk); bus.key_mode = 1'b0;
    endtask

    // One vsync pulse; kn=1 puts key_next on the same cycle as the frame start.
    task automatic frame(input bit kn);
        @(negedge clk); bus.vsync = 1'b1; bus.key_next = kn;
        @(negedge clk); bus.key_next = 1'b0;
        @(negedge clk); bus.vsync = 1'b0;
        cyc(3);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.vsync = 1'b0;
        bus.key_next = 1'b0;
        bus.key_mode = 1'b0;

        // T1: vsync toggling under reset, then release while vsync is high.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus.vsync = ~bus.vsync;
        end
        check("rst_pat_sel", int'(bus.pat_sel), 0);
        check("rst_mode", int'(bus.mode), 0);
        @(negedge clk); bus.vsync = 1'b1;
        @(negedge clk); rst_n = 1'b1; bus.key_next = 1'b1;
        @(negedge clk); bus.key_next = 1'b0;
        check("rel_no_fs_pat", int'(bus.pat_sel), 0);
        check("rel_no_fs_chg", int'(bus.pat_chg), 0);
        cyc(2);
        @(negedge clk); bus.vsync = 1'b0;
        cyc(3);
        check("rel_still_0", int'(bus.pat_sel), 0);
        frame(1'b0);
        check("rel_pend_adv", int'(bus.pat_sel), 1);

        // T2: mid-frame press waits for the frame start; three presses give one step.
        pulse_next();
        cyc(2);
        check("man_wait", int'(bus.pat_sel), 1);
        frame(1'b0);
        check("man_adv", int'(bus.pat_sel), 2);
        pulse_next(); pulse_next(); pulse_next();
        frame(1'b0);
        check("man_triple", int'(bus.pat_sel), 3);
        frame(1'b0);
        check("man_idle_frame", int'(bus.pat_sel), 3);

        // T3: wrap at PAT_NUM-1.
        pulse_next(); frame(1'b0);
        check("wrap_pre", int'(bus.pat_sel), 4);
        pulse_next(); frame(1'b0);
        check("wrap", int'(bus.pat_sel), 0);

        // T4: auto, step every third frame.
        pulse_mode();
        check("auto_mode", int'(bus.mode), 1);
        for (int f = 1; f <= 9; f++) begin
            frame(1'b0);
            check("auto_cnt", int'(bus.frame_cnt), f % 3);
            check("auto_pat", int'(bus.pat_sel), f / 3);
        end

        // T5: forced advance, pending and coincident.
        frame(1'b0);
        check("force_cnt1", int'(bus.frame_cnt), 1);
        pulse_next(); frame(1'b0);
        check("force_pend_pat", int'(bus.pat_sel), 4);
        check("force_pend_cnt", int'(bus.frame_cnt), 0);
        frame(1'b1);
        check("force_coinc_pat", int'(bus.pat_sel), 0);
        check("force_coinc_cnt", int'(bus.frame_cnt), 0);

        // T6: mode+next+fs collision from MANUAL.
        pulse_mode();
        check("back_manual", int'(bus.mode), 0);
        @(negedge clk); bus.vsync = 1'b1; bus.key_mode = 1'b1; bus.key_next = 1'b1;
        @(posedge clk); #1;
        check("coll_mode", int'(bus.mode), 1);
        check("coll_pat", int'(bus.pat_sel), 0);
        check("coll_cnt", int'(bus.frame_cnt), 0);
        check("coll_chg", int'(bus.pat_chg), 0);
        @(negedge clk); bus.key_mode = 1'b0; bus.key_next = 1'b0;
        @(negedge clk); bus.vsync = 1'b0;
        cyc(3);

        // T6: reset while a manual request is pending.
        pulse_mode();
        pulse_next(); frame(1'b0);
        check("pre_rst_pat", int'(bus.pat_sel), 1);
        pulse_next();
        #3 rst_n = 1'b0;
        #1 check("rst_async_pat", int'(bus.pat_sel), 0);
        @(negedge clk); rst_n = 1'b1;
        cyc(2);
        frame(1'b0);
        check("rst_pend_lost", int'(bus.pat_sel), 0);
        check("rst_pend_mode", int'(bus.mode), 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
